// File: rtl/cache_data_ways.sv
// -----------------------------------------------------------------------------
// cache_data_ways
//   Multi-way cache data array. It has an independent write port with byte
//   strobes and an independent read port with a registered read. A read returns
//   every way of one set. The returned data stays coherent with the array:
//   a write to the same set in the read cycle, a write while the read is in
//   flight, and a write while the result is held are all merged byte by byte
//   into rdata_o.
//
// Parameters
//   LINE     sets per way
//   BLOCK    32-bit words per line
//   WAYS     number of ways
//   OUT_REG  0: read latency 1, 1: extra output register (read latency 2)
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high. Blocks reads and writes
//   ren_i          read request for rindex_i in this cycle
//   rindex_i       read set index
//   wway_i         ways to write (one-hot or multi-hot)
//   wen_i          byte strobes. Bit b covers wdata_i[8b+7:8b]
//   windex_i       write set index
//   wdata_i        write data, the same for every selected way
//   rvalid_o       rdata_o holds a completed read
//   rdata_index_o  set index that rdata_o belongs to
//   rdata_o        way w at [w*LW +: LW]
// -----------------------------------------------------------------------------
module cache_data_ways #(
  parameter int LINE    = 128,
  parameter int BLOCK   = 8,
  parameter int WAYS    = 2,
  parameter int OUT_REG = 0,
  localparam int IW     = $clog2(LINE),
  localparam int LW     = 32 * BLOCK,
  localparam int NB     = 4 * BLOCK
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ren_i,
  input  logic [IW-1:0]        rindex_i,
  input  logic [WAYS-1:0]      wway_i,
  input  logic [NB-1:0]        wen_i,
  input  logic [IW-1:0]        windex_i,
  input  logic [LW-1:0]        wdata_i,
  output logic                 rvalid_o,
  output logic [IW-1:0]        rdata_index_o,
  output logic [WAYS*LW-1:0]   rdata_o
);

  // Replace the bytes of base that are selected by mask with the bytes of data.
  function automatic logic [WAYS*LW-1:0] merge_bytes(
    input logic [WAYS*LW-1:0] base,
    input logic [WAYS*NB-1:0] mask,
    input logic [WAYS*LW-1:0] data
  );
    logic [WAYS*LW-1:0] res;
    res = base;
    for (int i = 0; i < WAYS*NB; i++) begin
      if (mask[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  logic                     wfire;
  logic                     rfire;
  logic [WAYS*NB-1:0]       wmask;      // per-way, per-byte write strobe
  logic [WAYS*LW-1:0]       wdata_all;  // write data placed in every way slot

  assign wfire     = !rst_i && (|wen_i) && (|wway_i);
  assign rfire     = !rst_i && ren_i;
  assign wdata_all = {WAYS{wdata_i}};

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wmask = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < NB; b++) begin
        wmask[w*NB + b] = wway_i[w] & wen_i[b];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array: one simple dual-port, read-first RAM per way with byte writes.
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0][LW-1:0] ram_rd;

  for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
    logic [LW-1:0] mem_q [LINE];
    logic [LW-1:0] rd_q;

    // NOTE: the array and its read register are not reset. This keeps the block
    // inferable as RAM. The non-blocking read returns the contents from before
    // any write at the same edge (read-first).
    always_ff @(posedge clk_i) begin
      if (wfire && wway_i[gw]) begin
        for (int b = 0; b < NB; b++) begin
          if (wen_i[b]) mem_q[windex_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      if (rfire) rd_q <= mem_q[rindex_i];
    end

    assign ram_rd[gw] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Read stage A. The RAM output register is frozen until the next read. A
  // patch (byte mask plus data) collects every write to the read set that
  // fires from the issue cycle onward. The visible data is the RAM output with
  // the patch laid over it. At reset the patch covers every byte with zero, so
  // rdata reads 0 without resetting the RAM.
  // ---------------------------------------------------------------------------
  logic                 a_valid_q, a_valid_d;
  logic [IW-1:0]        a_index_q, a_index_d;
  logic [WAYS*NB-1:0]   patch_mask_q, patch_mask_d;
  logic [WAYS*LW-1:0]   patch_data_q, patch_data_d;
  logic                 a_hit;
  logic [WAYS*LW-1:0]   a_rdata;

  assign a_hit   = wfire && a_valid_q && (windex_i == a_index_q);
  assign a_rdata = merge_bytes(ram_rd, patch_mask_q, patch_data_q);

  always_comb begin
    a_valid_d    = a_valid_q;
    a_index_d    = a_index_q;
    patch_mask_d = patch_mask_q;
    patch_data_d = patch_data_q;
    if (rfire) begin
      // The new read replaces the old patch. A write to the same set in the
      // same cycle lands after the read-first RAM access, so it seeds the patch.
      a_valid_d    = 1'b1;
      a_index_d    = rindex_i;
      patch_mask_d = (wfire && (windex_i == rindex_i)) ? wmask : '0;
      patch_data_d = wdata_all;
    end else if (a_hit) begin
      patch_mask_d = patch_mask_q | wmask;
      patch_data_d = merge_bytes(patch_data_q, wmask, wdata_all);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid_q    <= 1'b0;
      a_index_q    <= '0;
      patch_mask_q <= '1;
      patch_data_q <= '0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_index_q    <= a_index_d;
      patch_mask_q <= patch_mask_d;
      patch_data_q <= patch_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output stage B. It captures stage A one cycle after issue, and a
  // write to the same set in that cycle is merged on the way in. While B holds
  // its result it merges writes to its own set.
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic                 pend_q;
    logic                 b_valid_q, b_valid_d;
    logic [IW-1:0]        b_index_q, b_index_d;
    logic [WAYS*LW-1:0]   b_data_q, b_data_d;
    logic                 b_hit;

    assign b_hit = wfire && b_valid_q && (windex_i == b_index_q);

    always_comb begin
      b_valid_d = b_valid_q;
      b_index_d = b_index_q;
      b_data_d  = b_data_q;
      if (pend_q) begin
        b_valid_d = 1'b1;
        b_index_d = a_index_q;
        b_data_d  = a_hit ? merge_bytes(a_rdata, wmask, wdata_all) : a_rdata;
      end else if (b_hit) begin
        b_data_d  = merge_bytes(b_data_q, wmask, wdata_all);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pend_q    <= 1'b0;
        b_valid_q <= 1'b0;
        b_index_q <= '0;
        b_data_q  <= '0;
      end else begin
        pend_q    <= ren_i;
        b_valid_q <= b_valid_d;
        b_index_q <= b_index_d;
        b_data_q  <= b_data_d;
      end
    end

    assign rvalid_o      = b_valid_q;
    assign rdata_index_o = b_index_q;
    assign rdata_o       = b_data_q;
  end else begin : g_no_out_reg
    assign rvalid_o      = a_valid_q;
    assign rdata_index_o = a_index_q;
    assign rdata_o       = a_rdata;
  end

endmodule
